// File: rtl/decode_control_mc.sv
// decode_control_mc: multi-cycle stack-machine decoder/controller.
// Accepts one instruction per handshake, walks DECODE/EXEC/MEM/COMMIT,
// tracks stack depth and latches a sticky fault on under/overflow or
// data-memory timeout.
module decode_control_mc #(
  parameter int REG_BITS    = 32,
  parameter int STACK_DEPTH = 16,
  parameter int MEM_TIMEOUT = 8,
  localparam int DEPTH_BITS = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [REG_BITS-1:0]   instruction,
  input  logic                  mem_ready,
  output logic [1:0]            ALUOp,
  output logic [1:0]            PCSrc,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [1:0]            StackWriteSrc,
  output logic                  ALUSrc,
  output logic [1:0]            StackUpdateMode,
  output logic                  pc_write,
  output logic                  stack_write,
  output logic [DEPTH_BITS-1:0] depth,
  output logic                  fault,
  output logic [1:0]            fault_code
);
  // Two extra bits so depth+1 and depth-2 never wrap for any STACK_DEPTH.
  localparam int SW = DEPTH_BITS + 2;
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic signed [SW-1:0] LIMIT    = SW'(STACK_DEPTH);
  localparam logic [CW-1:0]        TMO_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_MEM, S_COMMIT, S_FAULT
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic [1:0] sws;
    logic       alu_src;
    logic [1:0] mode;
  } ctrl_t;

  typedef struct packed {
    ctrl_t      ctrl;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] min_ops;
  } dec_t;

  state_t                  state_q;
  logic [REG_BITS-1:0]     ir_q;
  ctrl_t                   ctrl_q;
  logic                    mem_rd_q, mem_wr_q;
  logic                    mem_read_q, mem_write_q;
  logic                    pc_write_q, stack_write_q;
  logic                    rdy_q;
  logic [DEPTH_BITS-1:0]   depth_q;
  logic [DEPTH_BITS-1:0]   depth_d;
  logic                    fault_q;
  logic [1:0]              code_q;
  logic [CW-1:0]           tmo_q;

  dec_t                    dec_c;
  logic signed [SW-1:0]    depth_s, min_s, sum_s;
  logic                    underflow_c, overflow_c;

  function automatic dec_t decode(input logic [2:0] op1, input logic [2:0] op2);
    dec_t d;
    logic unary;
    unary = (op2 == 3'b111) || (op2 == 3'b010);
    d = '0;
    case (op1)
      3'b000: begin
        d.ctrl.alu_op = 2'b01; d.ctrl.sws = 2'b01;
        d.ctrl.mode   = unary ? 2'b00 : 2'b11;
        d.min_ops     = unary ? 2'd1 : 2'd2;
      end
      3'b001: begin
        d.ctrl.alu_op = 2'b01; d.ctrl.sws = 2'b01; d.ctrl.alu_src = 1'b1;
        d.ctrl.mode   = unary ? 2'b01 : 2'b00;
        d.min_ops     = unary ? 2'd0 : 2'd1;
      end
      3'b010: begin
        d.mem_rd = 1'b1; d.ctrl.sws = 2'b10; d.ctrl.mode = 2'b00; d.min_ops = 2'd1;
      end
      3'b011: begin
        d.mem_wr = 1'b1; d.ctrl.mode = 2'b10; d.min_ops = 2'd2;
      end
      3'b100: begin
        d.ctrl.alu_op = 2'b10; d.ctrl.sws = 2'b01; d.ctrl.mode = 2'b11; d.min_ops = 2'd2;
      end
      3'b101: begin
        d.ctrl.pc_src = 2'b01; d.ctrl.mode = 2'b10; d.min_ops = 2'd2;
      end
      3'b110: begin
        d.ctrl.sws = 2'b11; d.ctrl.mode = 2'b01; d.min_ops = 2'd0;
      end
      default: begin
        d.ctrl.pc_src = 2'b10; d.ctrl.mode = 2'b11; d.min_ops = 2'd1;
      end
    endcase
    return d;
  endfunction

  function automatic logic signed [SW-1:0] mode_delta(input logic [1:0] mode);
    case (mode)
      2'b01:   return SW'(1);
      2'b10:   return SW'(-2);
      2'b11:   return SW'(-1);
      default: return SW'(0);
    endcase
  endfunction

  // Decode the latched IR and evaluate the stack-depth checks; IR is stable
  // from DECODE through COMMIT, so the same sum serves as the commit update.
  always_comb begin
    dec_c       = decode(ir_q[REG_BITS-1 -: 3], ir_q[REG_BITS-4 -: 3]);
    depth_s     = SW'(depth_q);
    min_s       = SW'(dec_c.min_ops);
    sum_s       = depth_s + mode_delta(dec_c.ctrl.mode);
    underflow_c = depth_s < min_s;
    overflow_c  = sum_s > LIMIT;
    depth_d     = sum_s[DEPTH_BITS-1:0];
  end

  // Instruction register: captured only on an accepted handshake.
  always_ff @(posedge clk) begin
    if (instr_valid && rdy_q) ir_q <= instruction;
  end

  // Controller FSM with registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ctrl_q        <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      pc_write_q    <= 1'b0;
      stack_write_q <= 1'b0;
      rdy_q         <= 1'b1;
      depth_q       <= '0;
      fault_q       <= 1'b0;
      code_q        <= 2'b00;
      tmo_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            state_q <= S_DECODE;
            rdy_q   <= 1'b0;
          end
        end
        S_DECODE: begin
          if (underflow_c) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
            code_q  <= 2'b01;
          end else if (overflow_c) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
            code_q  <= 2'b10;
          end else begin
            state_q  <= S_EXEC;
            ctrl_q   <= dec_c.ctrl;
            mem_rd_q <= dec_c.mem_rd;
            mem_wr_q <= dec_c.mem_wr;
          end
        end
        S_EXEC: begin
          tmo_q <= '0;
          if (mem_rd_q || mem_wr_q) begin
            state_q     <= S_MEM;
            mem_read_q  <= mem_rd_q;
            mem_write_q <= mem_wr_q;
          end else begin
            state_q       <= S_COMMIT;
            pc_write_q    <= 1'b1;
            stack_write_q <= (ctrl_q.sws != 2'b00);
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            state_q       <= S_COMMIT;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            pc_write_q    <= 1'b1;
            stack_write_q <= (ctrl_q.sws != 2'b00);
          end else if (tmo_q == TMO_LAST) begin
            state_q     <= S_FAULT;
            ctrl_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            fault_q     <= 1'b1;
            code_q      <= 2'b11;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_COMMIT: begin
          state_q       <= S_IDLE;
          depth_q       <= depth_d;
          ctrl_q        <= '0;
          pc_write_q    <= 1'b0;
          stack_write_q <= 1'b0;
          rdy_q         <= 1'b1;
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          state_q <= S_FAULT;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  assign instr_ready     = rdy_q;
  assign ALUOp           = ctrl_q.alu_op;
  assign PCSrc           = ctrl_q.pc_src;
  assign StackWriteSrc   = ctrl_q.sws;
  assign ALUSrc          = ctrl_q.alu_src;
  assign StackUpdateMode = ctrl_q.mode;
  assign MemRead         = mem_read_q;
  assign MemWrite        = mem_write_q;
  assign pc_write        = pc_write_q;
  assign stack_write     = stack_write_q;
  assign depth           = depth_q;
  assign fault           = fault_q;
  assign fault_code      = code_q;

endmodule

// File: tb/tb_decode_control_mc.sv
// Bench for decode_control_mc: directed instruction sequence with a
// scoreboard of expected commit/fault responses and a decoupled monitor.
module tb_decode_control_mc;
  localparam int RB = 32;
  localparam int SD = 2;
  localparam int MT = 4;
  localparam int DB = $clog2(SD + 1);

  logic          clk, reset, instr_valid, instr_ready, mem_ready;
  logic          MemRead, MemWrite, ALUSrc, pc_write, stack_write, fault;
  logic [RB-1:0] instruction;
  logic [1:0]    ALUOp, PCSrc, StackWriteSrc, StackUpdateMode, fault_code;
  logic [DB-1:0] depth;

  typedef struct {
    logic       is_fault;
    logic [1:0] code;
    logic [1:0] alu;
    logic [1:0] pcs;
    logic [1:0] sws;
    logic       src;
    logic [1:0] mode;
    logic       sw;
    int         dep;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  decode_control_mc #(.REG_BITS(RB), .STACK_DEPTH(SD), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .mem_ready(mem_ready), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .StackWriteSrc(StackWriteSrc),
    .ALUSrc(ALUSrc), .StackUpdateMode(StackUpdateMode), .pc_write(pc_write),
    .stack_write(stack_write), .depth(depth), .fault(fault), .fault_code(fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endfunction

  function automatic logic [12:0] ctrl_vec();
    return {ALUOp, PCSrc, MemRead, MemWrite, StackWriteSrc, ALUSrc, StackUpdateMode,
            pc_write, stack_write};
  endfunction

  task automatic exp_commit(input logic [1:0] alu, input logic [1:0] pcs, input logic [1:0] sws,
                            input logic src, input logic [1:0] mode, input logic sw, input int dep);
    exp_t e;
    e.is_fault = 1'b0; e.code = 2'b00; e.alu = alu; e.pcs = pcs; e.sws = sws;
    e.src = src; e.mode = mode; e.sw = sw; e.dep = dep;
    sbq.push_back(e);
  endtask

  task automatic exp_fault(input logic [1:0] code, input int dep);
    exp_t e;
    e.is_fault = 1'b1; e.code = code; e.alu = 2'b00; e.pcs = 2'b00; e.sws = 2'b00;
    e.src = 1'b0; e.mode = 2'b00; e.sw = 1'b0; e.dep = dep;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Issue one instruction and follow it until IDLE or FAULT. Cycle numbers
  // count from 1 = first cycle after the handshake edge.
  task automatic run_instr(input logic [31:0] instr, input int lowcnt,
                           output int pc_cyc, output int pc_cnt, output int mem_cyc,
                           output int flt_cyc, output int end_cyc);
    int w;
    pc_cyc = 0; pc_cnt = 0; mem_cyc = 0; flt_cyc = 0; end_cyc = 0;
    w = 0;
    while (!instr_ready && w < 50) begin
      tick();
      w++;
    end
    if (!instr_ready) check("wait_instr_ready", instr_ready, 1);
    instr_valid = 1'b1;
    instruction = instr;
    tick();
    instr_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (pc_write) begin
        pc_cnt++;
        if (pc_cyc == 0) pc_cyc = k;
      end
      if (MemRead || MemWrite) mem_cyc++;
      if (fault) begin
        flt_cyc = k; end_cyc = k;
        break;
      end
      if (instr_ready) begin
        end_cyc = k;
        break;
      end
      mem_ready = (MemRead || MemWrite) && (mem_cyc > lowcnt);
      tick();
    end
    mem_ready = 1'b0;
    if (end_cyc == 0) check("run_cycle_bound", 0, 1);
  endtask

  task automatic push_op(input int dep);
    int a, b, c, d, e;
    exp_commit(2'b00, 2'b00, 2'b11, 1'b0, 2'b01, 1'b1, dep);
    run_instr(32'hC000_0000, 0, a, b, c, d, e);
    check("push_depth", depth, dep);
  endtask

  // Monitor: pops the scoreboard on every commit strobe or fault onset.
  initial begin : monitor
    logic fault_prev;
    logic dpend;
    int   dexp;
    exp_t e;
    fault_prev = 1'b0; dpend = 1'b0; dexp = 0;
    forever begin
      @(negedge clk);
      if (dpend) begin
        check("sb_depth_after_commit", depth, dexp);
        dpend = 1'b0;
      end
      if (pc_write) begin
        if (sbq.size() == 0) check("sb_unexpected_commit", pc_write, 0);
        else begin
          e = sbq.pop_front();
          check("sb_kind_commit", fault, e.is_fault);
          check("sb_ALUOp", ALUOp, e.alu);
          check("sb_PCSrc", PCSrc, e.pcs);
          check("sb_StackWriteSrc", StackWriteSrc, e.sws);
          check("sb_ALUSrc", ALUSrc, e.src);
          check("sb_StackUpdateMode", StackUpdateMode, e.mode);
          check("sb_stack_write", stack_write, e.sw);
          check("sb_memrw_at_commit", {MemRead, MemWrite}, 0);
          dexp = e.dep; dpend = 1'b1;
        end
      end
      if (fault && !fault_prev) begin
        if (sbq.size() == 0) check("sb_unexpected_fault", fault, 0);
        else begin
          e = sbq.pop_front();
          check("sb_kind_fault", fault, e.is_fault);
          check("sb_fault_code", fault_code, e.code);
          check("sb_fault_depth", depth, e.dep);
          check("sb_fault_ctrl", ctrl_vec(), 0);
        end
      end
      fault_prev = fault;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int pc, pcn, mc, fc, ec, bad;
    reset = 1'b1; instr_valid = 1'b0; instruction = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr_ready", instr_ready, 1);
    check("rst_ctrl", ctrl_vec(), 0);
    check("rst_depth", depth, 0);
    check("rst_fault", {fault, fault_code}, 0);
    reset = 1'b0;

    // Push: non-memory latency and commit controls.
    exp_commit(2'b00, 2'b00, 2'b11, 1'b0, 2'b01, 1'b1, 1);
    run_instr(32'hC000_0000, 0, pc, pcn, mc, fc, ec);
    check("push_pc_cycle", pc, 3);
    check("push_pc_count", pcn, 1);
    check("push_idle_cycle", ec, 4);
    check("push_no_mem", mc, 0);
    check("push_depth1", depth, 1);

    // Fill to the limit, then overflow.
    push_op(2);
    exp_fault(2'b10, 2);
    run_instr(32'hC000_0000, 0, pc, pcn, mc, fc, ec);
    check("ovf_fault_cycle", fc, 2);
    check("ovf_no_pc_write", pcn, 0);
    check("ovf_depth", depth, 2);

    // Underflow from empty stack; fault is absorbing.
    do_reset();
    exp_fault(2'b01, 0);
    run_instr(32'h0000_0000, 0, pc, pcn, mc, fc, ec);
    check("unf_fault_cycle", fc, 2);
    bad = 0;
    instr_valid = 1'b1; instruction = 32'hC000_0000;
    for (int i = 0; i < 20; i++) begin
      if (instr_ready !== 1'b0 || fault !== 1'b1 || depth !== '0 || pc_write !== 1'b0 ||
          fault_code !== 2'b01) bad++;
      tick();
    end
    instr_valid = 1'b0;
    check("unf_hold_violations", bad, 0);

    // Load with three stalled MEM cycles.
    do_reset();
    push_op(1);
    exp_commit(2'b00, 2'b00, 2'b10, 1'b0, 2'b00, 1'b1, 1);
    run_instr(32'h4000_0000, 3, pc, pcn, mc, fc, ec);
    check("ld_memread_cycles", mc, 4);
    check("ld_pc_cycle", pc, 7);
    check("ld_depth", depth, 1);

    // Store that times out.
    push_op(2);
    exp_fault(2'b11, 2);
    run_instr(32'h6000_0000, 99, pc, pcn, mc, fc, ec);
    check("st_tmo_memwrite_cycles", mc, 4);
    check("st_tmo_fault_cycle", fc, 7);
    check("st_tmo_no_pc_write", pcn, 0);
    check("st_tmo_memwrite_low", MemWrite, 0);
    check("st_tmo_depth", depth, 2);

    // Store with mem_ready on the last allowed MEM cycle.
    do_reset();
    push_op(1);
    push_op(2);
    exp_commit(2'b00, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 0);
    run_instr(32'h6000_0000, 3, pc, pcn, mc, fc, ec);
    check("st_last_memwrite_cycles", mc, 4);
    check("st_last_pc_cycle", pc, 7);
    check("st_last_fault", fault, 0);
    check("st_last_depth", depth, 0);

    // Comparator, group1 unary immediate, branch.
    push_op(1);
    push_op(2);
    exp_commit(2'b10, 2'b00, 2'b01, 1'b0, 2'b11, 1'b1, 1);
    run_instr(32'h8000_0000, 0, pc, pcn, mc, fc, ec);
    exp_commit(2'b01, 2'b00, 2'b01, 1'b1, 2'b01, 1'b1, 2);
    run_instr(32'h3C00_0000, 0, pc, pcn, mc, fc, ec);
    exp_commit(2'b00, 2'b01, 2'b00, 1'b0, 2'b10, 1'b0, 0);
    run_instr(32'hA000_0000, 0, pc, pcn, mc, fc, ec);
    check("mix_depth", depth, 0);

    // Reset while a load waits in MEM.
    push_op(1);
    instr_valid = 1'b1; instruction = 32'h4000_0000;
    tick();
    instr_valid = 1'b0;
    for (int i = 0; i < 10 && !MemRead; i++) tick();
    check("rstmem_reached_mem", MemRead, 1);
    reset = 1'b1;
    tick();
    check("rstmem_instr_ready", instr_ready, 1);
    check("rstmem_ctrl", ctrl_vec(), 0);
    check("rstmem_depth", depth, 0);
    check("rstmem_fault", {fault, fault_code}, 0);
    reset = 1'b0;
    repeat (4) tick();
    check("rstmem_depth_later", depth, 0);
    check("sb_queue_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
